controlador_display: RTL

CONTROLADOR_DISPLAY -- requirements
Module: controlador_display

---
 rtl/display_pkg.sv | 32 +++
 rtl/bin_a_bcd.sv | 98 +++++++++
 rtl/controlador_display.sv | 83 ++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment display controller.
package display_pkg;

    typedef enum logic {
        REPOSO    = 1'b0,
        CONVIERTE = 1'b1
    } estado_t;

    localparam int unsigned ITER   = 14;
    localparam int unsigned DATO_W = 14;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [DATO_W-1:0] MAX_VALIDO = 14'd9999;

    // Active-low segments ordered {g,f,e,d,c,b,a}; entry n is the code for digit n.
    localparam logic [9:0][SEG_W-1:0] SEG_TABLA = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [SEG_W-1:0] DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

    function automatic logic [SEG_W-1:0] seg_codigo(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_TABLA[d];
        end
        return BLANK;
    endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble converter: one iteration per cycle, result and
// overflow flag published together on the final iteration edge.
module bin_a_bcd
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic [DATO_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              fin,
    output logic              desborde
);

    estado_t           estado_q, estado_d;
    logic [DATO_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              fin_q, fin_d;
    logic              desborde_q, desborde_d;
    logic [BCD_W-1:0]  ajuste;
    logic [BCD_W-1:0]  paso;

    // One double-dabble step on the scratch register.
    always_comb begin
        ajuste = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (ajuste[4*i +: 4] >= 4'd5) begin
                ajuste[4*i +: 4] = ajuste[4*i +: 4] + 4'd3;
            end
        end
        paso = {ajuste[BCD_W-2:0], sh_q[DATO_W-1]};
    end

    always_comb begin
        estado_d   = estado_q;
        sh_d       = sh_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        fin_d      = fin_q;
        desborde_d = desborde_q;
        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    sh_d      = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_d     = (bin > MAX_VALIDO);
                    fin_d     = 1'b0;
                    estado_d  = CONVIERTE;
                end
            end
            CONVIERTE: begin
                sh_d      = {sh_q[DATO_W-2:0], 1'b0};
                scratch_d = paso;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    bcd_d      = paso;
                    desborde_d = ovf_q;
                    fin_d      = 1'b1;
                    estado_d   = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= REPOSO;
            sh_q       <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            fin_q      <= 1'b1;
            desborde_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sh_q       <= sh_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            fin_q      <= fin_d;
            desborde_q <= desborde_d;
        end
    end

    assign bcd      = bcd_q;
    assign fin      = fin_q;
    assign desborde = desborde_q;

endmodule

// File: rtl/controlador_display.sv
// Four-digit multiplexed seven-segment controller: converts a binary value to
// BCD and scans it out with optional leading-zero blanking.
module controlador_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATO_W-1:0] dato,
    input  logic              cargar,
    input  logic              supr_ceros,
    output logic              listo,
    output logic              error,
    output logic [3:0]        an,
    output logic [SEG_W-1:0]  seg
);

    logic [BCD_W-1:0]        digitos;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [1:0]              sel;
    logic [3:0]              digito;
    logic [3:0]              blanco;

    // The converter ignores inicio while busy, so cargar is never queued.
    bin_a_bcd u_conv (
        .clk      (clk),
        .rst      (rst),
        .inicio   (cargar),
        .bin      (dato),
        .bcd      (digitos),
        .fin      (listo),
        .desborde (error)
    );

    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    // A digit is blank only if it and every more significant digit are zero.
    always_comb begin
        blanco    = '0;
        blanco[3] = supr_ceros && (digitos[15:12] == 4'd0);
        blanco[2] = blanco[3]  && (digitos[11:8]  == 4'd0);
        blanco[1] = blanco[2]  && (digitos[7:4]   == 4'd0);
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        an_d      = 4'b1110;
        digito    = digitos[3:0];
        case (sel)
            2'd0: begin an_d = 4'b1110; digito = digitos[3:0];   end
            2'd1: begin an_d = 4'b1101; digito = digitos[7:4];   end
            2'd2: begin an_d = 4'b1011; digito = digitos[11:8];  end
            2'd3: begin an_d = 4'b0111; digito = digitos[15:12]; end
            default: begin an_d = 4'b1110; digito = digitos[3:0]; end
        endcase
        if (error) begin
            seg_d = DASH;
        end else if (blanco[sel]) begin
            seg_d = BLANK;
        end else begin
            seg_d = seg_codigo(digito);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            an_q      <= 4'b1111;
            seg_q     <= BLANK;
        end else begin
            refresh_q <= refresh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
